mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Bus responder that terminates the core's separate instruction and data memory buses. It arbitrates both onto a single downstream memory port. Each upstream bus sees an ordinary access/ack responder; the arbiter registers the winning request, holds it on the downstream port until the memory acknowledges, then returns read data and a one-cycle ack to the winner. It sits between the CPU core and the system memory/IO fabric.

## Interface
- No parameters.
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- instr_m_addr  in  19 [19:1]  instruction fetch word address
- instr_m_data_out  out  16  instruction read data
- instr_m_access  in  1  instruction request, held until ack
- instr_m_ack  out  1  one-cycle completion pulse
- data_m_addr  in  19 [19:1]  data word address
- data_m_data_in  in  16  write data from core
- data_m_data_out  out  16  read data to core
- data_m_access  in  1  data request, held until ack
- data_m_ack  out  1  one-cycle completion pulse
- data_m_wr_en  in  1  1 = write
- data_m_bytesel  in  2  byte enables, bit 0 = low byte
- d_io  in  1  data request targets IO space
- q_m_addr  out  19 [19:1]  downstream address
- q_m_data_in  in  16  downstream read data
- q_m_data_out  out  16  downstream write data
- q_m_access  out  1  downstream request
- q_m_ack  in  1  downstream completion
- q_m_wr_en  out  1  downstream write
- q_m_bytesel  out  2  downstream byte enables
- q_io  out  1  downstream IO qualifier

## Operation
- States:
  - IDLE: no grant.
  - SERVE_I: instruction granted.
  - SERVE_D: data granted.
  - ACK_I: instruction ack cycle.
  - ACK_D: data ack cycle.
- IDLE:
  - Any access high → grant chosen per Configuration, move to SERVE_x.
  - On the grant edge, register addr, wr_en, bytesel, write data and io into the q_m_* outputs, and set q_m_access=1.
- Instruction grant drives q_m_wr_en=0, q_m_bytesel=2'b11, q_io=0, q_m_data_out unchanged.
- SERVE_x:
  - q_m_access and all q_m_* outputs held stable.
  - On q_m_ack=1: capture q_m_data_in into the winner's data_out register, clear q_m_access, move to ACK_x.
- ACK_x:
  - Winner's ack=1 for exactly this cycle.
  - The winner's own access is ignored in this cycle; it is still high from the old request.
  - If the other port's access is high, grant it directly (ACK_I→SERVE_D, ACK_D→SERVE_I). Otherwise go to IDLE.
- Read data registers hold their value until the next ack on the same port.
- Write data is not returned; data_m_data_out is still updated from q_m_data_in on write acks (don't-care for the core).
- An initiator dropping access while in SERVE_x is a protocol violation; the transaction completes regardless.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Round-robin pointer = "instruction last".
- Reset assertion mid-transaction aborts immediately: q_m_access=0, no ack is issued, captured data is cleared.
- Latency:
  - access sampled high at edge 0 → q_m_access=1 after edge 0.
  - q_m_ack sampled at edge k (k≥1) → ack=1 after edge k for one cycle.
  - Minimum access-to-ack is 2 cycles.
- Back-to-back alternating ports: a new downstream request every 2 cycles when memory acks immediately. Same-port back-to-back passes through IDLE: 3 cycles.
- q_m_ack while q_m_access=0 is ignored.
- Simultaneous requests in IDLE are resolved in one cycle; the loser waits with its access held.

## Configuration
- ARB_ROUND_ROBIN_EN:
  - Defined: ties in IDLE go to the port not granted most recently. A 1-bit pointer updates on every grant.
  - Undefined: fixed priority, data always wins ties. The pointer is not implemented.
  - Non-tie grants are identical in both builds.

## Test plan
- Single instruction read:
  - Stimulus: instr_m_access=1, addr 19'h00100; memory acks 1 cycle later with 16'hBEEF.
  - Response: q_m_addr=19'h00100, q_m_wr_en=0, q_m_bytesel=2'b11; instr_m_ack pulses once with instr_m_data_out=16'hBEEF, 3 cycles after the request.
- Data byte write to IO:
  - Stimulus: data_m_wr_en=1, bytesel=2'b10, data 16'h5A00, d_io=1.
  - Response: q_m_wr_en=1, q_m_bytesel=2'b10, q_m_data_out=16'h5A00, q_io=1; data_m_ack pulses once.
- Simultaneous requests, fixed priority:
  - Stimulus: both accesses high in IDLE.
  - Response: data served first; instruction granted directly from ACK_D; instr_m_ack follows data_m_ack by 2 cycles with zero-wait memory.
- Simultaneous requests with ARB_ROUND_ROBIN_EN, repeated 4 times:
  - Response: grants alternate D,I,D,I starting with data.
- Wait states:
  - Stimulus: memory holds q_m_ack low 5 cycles.
  - Response: q_m_* stable for all 5 cycles, no upstream ack until 1 cycle after q_m_ack.
- Reset mid-SERVE_D:
  - Response: q_m_access=0 and data_m_ack=0 immediately, state IDLE; a subsequent request completes normally.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundles the arbiter's upstream instruction/data buses and its downstream memory port.
// slave: the arbiter's view. master: the core plus memory that surround it.
interface mem_arbiter_if;
  logic [19:1] instr_m_addr;
  logic [15:0] instr_m_data_out;
  logic        instr_m_access;
  logic        instr_m_ack;
  logic [19:1] data_m_addr;
  logic [15:0] data_m_data_in;
  logic [15:0] data_m_data_out;
  logic        data_m_access;
  logic        data_m_ack;
  logic        data_m_wr_en;
  logic [1:0]  data_m_bytesel;
  logic        d_io;
  logic [19:1] q_m_addr;
  logic [15:0] q_m_data_in;
  logic [15:0] q_m_data_out;
  logic        q_m_access;
  logic        q_m_ack;
  logic        q_m_wr_en;
  logic [1:0]  q_m_bytesel;
  logic        q_io;

  modport slave (
    input  instr_m_addr, instr_m_access, data_m_addr, data_m_data_in, data_m_access,
           data_m_wr_en, data_m_bytesel, d_io, q_m_data_in, q_m_ack,
    output instr_m_data_out, instr_m_ack, data_m_data_out, data_m_ack,
           q_m_addr, q_m_data_out, q_m_access, q_m_wr_en, q_m_bytesel, q_io
  );

  modport master (
    output instr_m_addr, instr_m_access, data_m_addr, data_m_data_in, data_m_access,
           data_m_wr_en, data_m_bytesel, d_io, q_m_data_in, q_m_ack,
    input  instr_m_data_out, instr_m_ack, data_m_data_out, data_m_ack,
           q_m_addr, q_m_data_out, q_m_access, q_m_wr_en, q_m_bytesel, q_io
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction and data buses onto one registered downstream memory port.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise data wins ties.
module mem_arbiter (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SERVE_I, SERVE_D, ACK_I, ACK_D} state_t;

  state_t state, next;
  logic   grant_i, grant_d, tie_d;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = data was granted most recently; reset value means "instruction last".
  logic last_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       last_d <= 1'b0;
    else if (grant_d) last_d <= 1'b1;
    else if (grant_i) last_d <= 1'b0;
  end

  assign tie_d = ~last_d;
`else
  assign tie_d = 1'b1;
`endif

  always_comb begin
    next    = state;
    grant_i = 1'b0;
    grant_d = 1'b0;
    case (state)
      IDLE: begin
        if (bus.data_m_access && (!bus.instr_m_access || tie_d)) grant_d = 1'b1;
        else if (bus.instr_m_access)                             grant_i = 1'b1;
      end
      SERVE_I: if (bus.q_m_ack) next = ACK_I;
      SERVE_D: if (bus.q_m_ack) next = ACK_D;
      // The winner's access is still high from the finished request, so only
      // the other port is considered here.
      ACK_I: if (bus.data_m_access)  grant_d = 1'b1; else next = IDLE;
      ACK_D: if (bus.instr_m_access) grant_i = 1'b1; else next = IDLE;
      default: next = IDLE;
    endcase
    if (grant_i) next = SERVE_I;
    if (grant_d) next = SERVE_D;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                <= IDLE;
      bus.q_m_addr         <= '0;
      bus.q_m_data_out     <= '0;
      bus.q_m_access       <= 1'b0;
      bus.q_m_wr_en        <= 1'b0;
      bus.q_m_bytesel      <= '0;
      bus.q_io             <= 1'b0;
      bus.instr_m_data_out <= '0;
      bus.instr_m_ack      <= 1'b0;
      bus.data_m_data_out  <= '0;
      bus.data_m_ack       <= 1'b0;
    end else begin
      state           <= next;
      bus.instr_m_ack <= (state == SERVE_I) && bus.q_m_ack;
      bus.data_m_ack  <= (state == SERVE_D) && bus.q_m_ack;
      if (grant_i) begin
        // Instruction fetches leave the write-data register untouched.
        bus.q_m_addr    <= bus.instr_m_addr;
        bus.q_m_wr_en   <= 1'b0;
        bus.q_m_bytesel <= 2'b11;
        bus.q_io        <= 1'b0;
        bus.q_m_access  <= 1'b1;
      end else if (grant_d) begin
        bus.q_m_addr     <= bus.data_m_addr;
        bus.q_m_data_out <= bus.data_m_data_in;
        bus.q_m_wr_en    <= bus.data_m_wr_en;
        bus.q_m_bytesel  <= bus.data_m_bytesel;
        bus.q_io         <= bus.d_io;
        bus.q_m_access   <= 1'b1;
      end else if (state == SERVE_I && bus.q_m_ack) begin
        bus.instr_m_data_out <= bus.q_m_data_in;
        bus.q_m_access       <= 1'b0;
      end else if (state == SERVE_D && bus.q_m_ack) begin
        bus.data_m_data_out <= bus.q_m_data_in;
        bus.q_m_access      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter: downstream requests and upstream acks
// are checked by monitors against queues filled when stimulus is issued.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   mem_wait = 0;
  logic [15:0] last_wdata = '0;

  typedef struct { logic [19:1] addr; logic [15:0] wdata; logic wr; logic [1:0] bsel; logic io; } req_t;
  typedef struct { logic port; logic [15:0] data; int cyc; } ack_t;

  req_t        req_q[$];
  ack_t        ack_q[$];
  logic [15:0] mem_q[$];

  mem_arbiter_if bus();

  mem_arbiter dut (.clk(clk), .reset(reset), .bus(bus.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory: acks after mem_wait cycles of q_m_access, returning queued read data.
  initial begin
    int cnt;
    cnt = 0;
    bus.q_m_ack = 1'b0;
    bus.q_m_data_in = '0;
    forever begin
      @(negedge clk);
      if (!reset || bus.q_m_ack) begin
        bus.q_m_ack = 1'b0;
        cnt = 0;
      end else if (bus.q_m_access) begin
        if (cnt >= mem_wait) begin
          bus.q_m_ack = 1'b1;
          bus.q_m_data_in = (mem_q.size() != 0) ? mem_q.pop_front() : 16'hDEAD;
        end else cnt++;
      end
    end
  end

  // Downstream monitor: new request matches scoreboard, then stays stable.
  initial begin
    logic prev;
    req_t cur, got;
    prev = 1'b0;
    cur = '{default: '0};
    forever begin
      @(negedge clk);
      got = '{bus.q_m_addr, bus.q_m_data_out, bus.q_m_wr_en, bus.q_m_bytesel, bus.q_io};
      if (bus.q_m_access && !prev) begin
        if (req_q.size() == 0) chk("unexpected_req", 1, 0);
        else begin
          cur = req_q.pop_front();
          chk("q_m_addr", 32'(got.addr), 32'(cur.addr));
          chk("q_m_data_out", 32'(got.wdata), 32'(cur.wdata));
          chk("q_m_wr_en", 32'(got.wr), 32'(cur.wr));
          chk("q_m_bytesel", 32'(got.bsel), 32'(cur.bsel));
          chk("q_io", 32'(got.io), 32'(cur.io));
        end
      end else if (bus.q_m_access && prev) begin
        chk("q_stable", {got.addr, got.wr, got.bsel, got.io}, {cur.addr, cur.wr, cur.bsel, cur.io});
        chk("q_stable_wdata", 32'(got.wdata), 32'(cur.wdata));
      end
      prev = bus.q_m_access;
    end
  end

  // Upstream monitor: each ack is a single-cycle pulse with the right port, data, cycle.
  initial begin
    logic pi, pd;
    ack_t e;
    pi = 1'b0;
    pd = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.instr_m_ack || bus.data_m_ack) begin
        if (bus.instr_m_ack && bus.data_m_ack) chk("dual_ack", 1, 0);
        if ((bus.instr_m_ack && pi) || (bus.data_m_ack && pd)) chk("ack_pulse_width", 2, 1);
        if (ack_q.size() == 0) chk("unexpected_ack", 1, 0);
        else begin
          e = ack_q.pop_front();
          chk("ack_port", 32'(bus.data_m_ack), 32'(e.port));
          chk("ack_data", 32'(bus.data_m_ack ? bus.data_m_data_out : bus.instr_m_data_out), 32'(e.data));
          chk("ack_cycle", cyc, e.cyc);
        end
      end
      pi = bus.instr_m_ack;
      pd = bus.data_m_ack;
    end
  end

  task automatic issue_i(input logic [19:1] a, input logic [15:0] rd, input int lat);
    bus.instr_m_addr = a;
    bus.instr_m_access = 1'b1;
    req_q.push_back('{a, last_wdata, 1'b0, 2'b11, 1'b0});
    mem_q.push_back(rd);
    ack_q.push_back('{1'b0, rd, cyc + lat});
  endtask

  task automatic issue_d(input logic [19:1] a, input logic [15:0] wd, input logic wr,
                         input logic [1:0] bs, input logic io, input logic [15:0] rd,
                         input int lat, input bit expect_ack);
    bus.data_m_addr = a;
    bus.data_m_data_in = wd;
    bus.data_m_wr_en = wr;
    bus.data_m_bytesel = bs;
    bus.d_io = io;
    bus.data_m_access = 1'b1;
    last_wdata = wd;
    req_q.push_back('{a, wd, wr, bs, io});
    if (expect_ack) begin
      mem_q.push_back(rd);
      ack_q.push_back('{1'b1, rd, cyc + lat});
    end
  endtask

  // Core behaviour: drop access on ack; bounded wait until both ports are quiet.
  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.instr_m_ack) bus.instr_m_access = 1'b0;
      if (bus.data_m_ack)  bus.data_m_access = 1'b0;
      if (!bus.instr_m_access && !bus.data_m_access) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("ack_timeout", 1, 0);
      bus.instr_m_access = 1'b0;
      bus.data_m_access = 1'b0;
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bus.instr_m_addr = '0;
    bus.instr_m_access = 1'b0;
    bus.data_m_addr = '0;
    bus.data_m_data_in = '0;
    bus.data_m_access = 1'b0;
    bus.data_m_wr_en = 1'b0;
    bus.data_m_bytesel = '0;
    bus.d_io = 1'b0;

    @(negedge clk);
    chk("rst_q_access", 32'(bus.q_m_access), 0);
    chk("rst_q_fields", {bus.q_m_addr, bus.q_m_wr_en, bus.q_m_bytesel, bus.q_io}, 0);
    chk("rst_data_outs", {bus.instr_m_data_out, bus.data_m_data_out}, 0);
    chk("rst_acks", {bus.instr_m_ack, bus.data_m_ack}, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Single instruction read, one memory wait state.
    mem_wait = 1;
    issue_i(19'h00100, 16'hBEEF, 3);
    wait_done();

    // Data byte write to IO.
    mem_wait = 0;
    @(negedge clk);
    issue_d(19'h40010, 16'h5A00, 1'b1, 2'b10, 1'b1, 16'h1234, 2, 1'b1);
    wait_done();
    chk("instr_data_hold", 32'(bus.instr_m_data_out), 32'h0000BEEF);

    // Instruction grant leaves write data as it was.
    @(negedge clk);
    issue_i(19'h00200, 16'h0AA5, 2);
    wait_done();

    // Tie after an instruction grant: data first in both builds.
    @(negedge clk);
    issue_d(19'h00300, 16'h0000, 1'b0, 2'b11, 1'b0, 16'h1111, 2, 1'b1);
    issue_i(19'h00400, 16'h2222, 4);
    wait_done();

    // Data alone, then a tie: round-robin favours instruction, fixed favours data.
    @(negedge clk);
    issue_d(19'h00500, 16'h0000, 1'b0, 2'b11, 1'b0, 16'h3333, 2, 1'b1);
    wait_done();
    @(negedge clk);
`ifdef ARB_ROUND_ROBIN_EN
    issue_i(19'h00700, 16'h5555, 2);
    issue_d(19'h00600, 16'h0000, 1'b0, 2'b11, 1'b0, 16'h4444, 4, 1'b1);
`else
    issue_d(19'h00600, 16'h0000, 1'b0, 2'b11, 1'b0, 16'h4444, 2, 1'b1);
    issue_i(19'h00700, 16'h5555, 4);
`endif
    wait_done();

    // Five wait states: downstream held stable, ack one cycle after q_m_ack.
    mem_wait = 5;
    @(negedge clk);
    issue_i(19'h00800, 16'h6666, 7);
    wait_done();

    // Reset in the middle of a data transaction.
    mem_wait = 10;
    @(negedge clk);
    issue_d(19'h00900, 16'hCAFE, 1'b1, 2'b11, 1'b0, 16'h0000, 0, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_mid_q_access", 32'(bus.q_m_access), 0);
    chk("rst_mid_data_ack", 32'(bus.data_m_ack), 0);
    chk("rst_mid_data_outs", {bus.instr_m_data_out, bus.data_m_data_out}, 0);
    bus.data_m_access = 1'b0;
    last_wdata = '0;
    mem_wait = 0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Four ties after reset: grants run D,I,D,I,... starting with data.
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      issue_d(19'(20'h01000 + r), 16'(16'h0100 * r), 1'b0, 2'b11, 1'b0, 16'(16'hD000 + r), 2, 1'b1);
      issue_i(19'(20'h02000 + r), 16'(16'hA000 + r), 4);
      wait_done();
    end

    chk("req_q_empty", req_q.size(), 0);
    chk("ack_q_empty", ack_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
